// File: rtl/pool_window_gen.sv
// Sliding KxK window generator over a raster pixel stream; windows on the stride grid, 1-cycle latency.
// No backpressure: one pixel accepted per px_vld, gaps of any length allowed.
module pool_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int WIN_SIZE   = 3,
    parameter int STRIDE     = 2,
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                                                  clk,
    input  logic                                                  reset_n,
    input  logic                                                  px_vld,
    input  logic                                                  sof,
    input  logic signed [DATA_WIDTH-1:0]                          px,
    output logic                                                  win_vld,
    output logic signed [WIN_SIZE-1:0][WIN_SIZE-1:0][DATA_WIDTH-1:0] win,
    output logic                                                  frame_done
);
    localparam int K  = WIN_SIZE;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef logic [DATA_WIDTH-1:0]        pix_t;
    typedef logic [K-1:0][DATA_WIDTH-1:0] col_t;

    logic [XW-1:0] x_q, cur_x;
    logic [YW-1:0] y_q, cur_y;
    logic [PW-1:0] xph_q, yph_q, cur_xph, cur_yph, nxt_xph, nxt_yph;
    logic          x_last, y_last, win_hit;

    pix_t lb [K-1][IMG_WIDTH];
    col_t col;
    col_t [K-1:0] sr_q, sr_nxt;
    logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_nxt;

    always_comb begin
        // sof restarts the frame at the pixel that carries it
        cur_x   = sof ? '0 : x_q;
        cur_y   = sof ? '0 : y_q;
        cur_xph = sof ? '0 : xph_q;
        cur_yph = sof ? '0 : yph_q;
        x_last  = (cur_x == XW'(IMG_WIDTH - 1));
        y_last  = (cur_y == YW'(IMG_HEIGHT - 1));

        col = '0;
        for (int r = 0; r < K - 1; r++) col[r] = lb[r][cur_x];
        col[K-1] = px;

        sr_nxt = sr_q;
        for (int c = 0; c < K - 1; c++) sr_nxt[c] = sr_q[c+1];
        sr_nxt[K-1] = col;

        win_nxt = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                win_nxt[r][c] = sr_nxt[c][r];

        // Phase counters stay 0 up to position K-1, then count modulo STRIDE
        if (x_last || (cur_x < XW'(K - 1)) || (cur_xph == PW'(STRIDE - 1)))
            nxt_xph = '0;
        else
            nxt_xph = cur_xph + PW'(1);
        if (y_last || (cur_y < YW'(K - 1)) || (cur_yph == PW'(STRIDE - 1)))
            nxt_yph = '0;
        else
            nxt_yph = cur_yph + PW'(1);

        win_hit = px_vld && (cur_x >= XW'(K - 1)) && (cur_y >= YW'(K - 1)) &&
                  (cur_xph == '0) && (cur_yph == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            xph_q      <= '0;
            yph_q      <= '0;
            sr_q       <= '0;
            win        <= '0;
            win_vld    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_vld    <= win_hit;
            frame_done <= px_vld && x_last && y_last;
            if (px_vld) begin
                x_q   <= x_last ? '0 : cur_x + XW'(1);
                xph_q <= nxt_xph;
                sr_q  <= sr_nxt;
                if (x_last) begin
                    y_q   <= y_last ? '0 : cur_y + YW'(1);
                    yph_q <= nxt_yph;
                end else begin
                    y_q   <= cur_y;
                    yph_q <= cur_yph;
                end
            end
            if (win_hit) win <= win_nxt;
        end
    end

    // Line buffers move up one row per accepted pixel; not reset
    always_ff @(posedge clk) begin
        if (px_vld) begin
            for (int i = 0; i < K - 1; i++) lb[i][cur_x] <= col[i+1];
        end
    end
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: ramp, gapped, extreme-value, aborted, reset and stride-1 frames.
module tb_pool_window_gen;
    typedef logic [2:0][2:0][7:0] win_t;

    logic clk = 1'b0;
    logic reset_n;
    logic vld0, sof0, vld1, sof1;
    logic signed [7:0] px0, px1;
    logic wv0, fd0, wv1, fd1;
    logic signed [2:0][2:0][7:0] w0, w1;

    always #5 clk = ~clk;

    pool_window_gen #(.DATA_WIDTH(8), .WIN_SIZE(3), .STRIDE(2), .IMG_WIDTH(16), .IMG_HEIGHT(16)) dut (
        .clk(clk), .reset_n(reset_n), .px_vld(vld0), .sof(sof0), .px(px0),
        .win_vld(wv0), .win(w0), .frame_done(fd0));

    pool_window_gen #(.DATA_WIDTH(8), .WIN_SIZE(3), .STRIDE(1), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_s1 (
        .clk(clk), .reset_n(reset_n), .px_vld(vld1), .sof(sof1), .px(px1),
        .win_vld(wv1), .win(w1), .frame_done(fd1));

    int   n_checks = 0, n_fail = 0;
    bit   sel;
    int   S, W, H, mode;
    bit   pend_win, pend_fd;
    win_t last_exp, first_win, last_win;
    int   win_cnt, run, max_run, n127;
    bit   coincide;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pix(int x, int y);
        if (mode == 1) return (x == 3 && y == 3) ? 127 : -128;
        return 8 * y + x - 64;
    endfunction

    function automatic win_t ref_win(int bx, int by);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r][c] = 8'(pix(bx - 2 + c, by - 2 + r));
        return w;
    endfunction

    task automatic clear_stats();
        win_cnt = 0; run = 0; max_run = 0; n127 = 0; coincide = 0;
    endtask

    task automatic verify();
        logic ov, ofd;
        win_t ow;
        ov  = sel ? wv1 : wv0;
        ofd = sel ? fd1 : fd0;
        ow  = sel ? w1 : w0;
        check("win_vld", ov, pend_win);
        check("frame_done", ofd, pend_fd);
        check("win", ow, last_exp);
        if (ov) begin
            win_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (win_cnt == 1) first_win = ow;
            last_win = ow;
            if (ofd) coincide = 1;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    if (ow[r][c] == 8'h7f) n127++;
        end else begin
            run = 0;
        end
    endtask

    task automatic step(input bit v, input bit s, input int x, input int y);
        @(negedge clk);
        verify();
        vld0 = !sel && v;  sof0 = !sel && s;
        vld1 = sel && v;   sof1 = sel && s;
        px0  = 8'(pix(x, y));
        px1  = 8'(pix(x, y));
        pend_win = v && x >= 2 && y >= 2 && ((x - 2) % S == 0) && ((y - 2) % S == 0);
        pend_fd  = v && x == W - 1 && y == H - 1;
        if (pend_win) last_exp = ref_win(x, y);
    endtask

    task automatic frame(input bit with_sof, input bit gaps, input int ax, input int ay);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (x == ax && y == ay) return;
                if (gaps) repeat ($urandom_range(0, 1)) step(0, 0, 0, 0);
                step(1, with_sof && x == 0 && y == 0, x, y);
            end
    endtask

    task automatic flush();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask

    task automatic check_first_ramp(input string tag);
        check({tag, "_first00"}, $signed(first_win[0][0]), -64);
        check({tag, "_first22"}, $signed(first_win[2][2]), -46);
        check({tag, "_first12"}, $signed(first_win[1][2]), -54);
        check({tag, "_last22"}, $signed(last_win[2][2]), 62);
        check({tag, "_count"}, win_cnt, 49);
    endtask

    initial begin
        vld0 = 0; sof0 = 0; px0 = 0; vld1 = 0; sof1 = 0; px1 = 0;
        sel = 0; S = 2; W = 16; H = 16; mode = 0;
        pend_win = 0; pend_fd = 0; last_exp = '0;
        clear_stats();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("rst_win_vld", wv0, 0);
        check("rst_frame_done", fd0, 0);
        check("rst_win", w0, 0);
        check("rst_s1_win", w1, 0);
        reset_n = 1'b1;

        // Ramp frame, continuous valid
        clear_stats();
        frame(1, 0, -1, -1);
        flush();
        check_first_ramp("ramp");

        // Same image with random valid gaps
        clear_stats();
        frame(1, 1, -1, -1);
        flush();
        check_first_ramp("gaps");

        // Negative extremes with a single positive pixel at (3,3)
        mode = 1;
        clear_stats();
        frame(1, 0, -1, -1);
        flush();
        check("ext_count", win_cnt, 49);
        check("ext_n127", n127, 1);
        mode = 0;

        // Frame aborted by sof at (5,7)
        frame(1, 0, 5, 7);
        clear_stats();
        frame(1, 0, -1, -1);
        flush();
        check("abort_first", first_win, ref_win(2, 2));
        check_first_ramp("abort");

        // Reset mid-frame, next frame without sof
        frame(1, 0, 9, 4);
        step(0, 0, 0, 0);
        reset_n = 1'b0;
        last_exp = '0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_win_vld", wv0, 0);
            check("midrst_frame_done", fd0, 0);
            check("midrst_win", w0, 0);
        end
        reset_n = 1'b1;
        clear_stats();
        frame(0, 0, -1, -1);
        flush();
        check_first_ramp("postrst");

        // Stride 1 on an 8x8 image
        sel = 1; S = 1; W = 8; H = 8;
        last_exp = '0;
        clear_stats();
        frame(1, 0, -1, -1);
        flush();
        check("s1_count", win_cnt, 36);
        check("s1_run", max_run, 6);
        check("s1_coincide", coincide, 1);
        check("s1_first", first_win, ref_win(2, 2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
